imem_boot_loader: RTL and testbench

//  Loads a program image into instruction memory from a byte stream, then releases the core.
//  - Upstream: a byte source such as a UART RX or debug link, using a valid/ready handshake.
//  - Downstream: the instruction-memory write port, plus the core reset.
//  - Holds the single-cycle core in reset until a complete, checksum-verified image is written.

---
 rtl/boot_pkg.sv | 25 ++
 rtl/imem_boot_loader_if.sv | 9 +
 rtl/boot_word_asm.sv | 42 ++++
 rtl/imem_boot_loader.sv | 198 +++++++++++++++++++
 tb/tb_imem_boot_loader.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package boot_pkg;

    typedef enum logic [2:0] {
        HDR   = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        CSUM  = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    localparam int HDR_BYTES  = 4;
    localparam int WORD_BYTES = 4;

    // Width of a counter that must hold the value TIMEOUT; never narrower than 1 bit.
    function automatic int tmo_width(input int unsigned timeout);
        if (timeout == 32'd0) begin
            return 1;
        end else begin
            return $clog2(timeout + 32'd1);
        end
    endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream valid/ready link feeding the boot loader.
interface imem_boot_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/boot_word_asm.sv
// Little-endian byte-to-word assembler, shared by the frame header and payload words.
module boot_word_asm
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        shift,
    input  logic [7:0]  din,
    output logic [31:0] word_next,
    output logic [1:0]  byte_idx,
    output logic        word_ready
);

    localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

    logic [31:0] sr_r;
    logic [1:0]  idx_r;

    // Incoming byte lands in the top lane, so after four shifts byte 0 sits in [7:0].
    assign word_next  = {din, sr_r[31:8]};
    assign byte_idx   = idx_r;
    assign word_ready = shift & (idx_r == LAST_IDX);

    // Shift register and byte index; the index wraps 3 -> 0 on its own.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_r  <= 32'd0;
            idx_r <= 2'd0;
        end else if (clr) begin
            sr_r  <= 32'd0;
            idx_r <= 2'd0;
        end else if (shift) begin
            sr_r  <= word_next;
            idx_r <= idx_r + 2'd1;
        end else begin
            sr_r  <= sr_r;
            idx_r <= idx_r;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Receives a length-prefixed, XOR-checked program image and writes it into
// instruction memory, keeping the core in reset until the image is verified.
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned TIMEOUT     = 100_000
) (
    input  logic                clk,
    input  logic                rst,
    imem_boot_loader_if.slave   bus,
    input  logic                start,
    output logic                imem_we,
    output logic [31:0]         imem_addr,
    output logic [31:0]         imem_wdata,
    output logic                core_rst_n,
    output logic                done,
    output logic                err,
    output logic [15:0]         words_loaded
);

    localparam int TW = tmo_width(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT == 32'd0) ? 32'd0 : TIMEOUT - 32'd1);
    localparam logic [31:0]   DEPTH_32 = 32'(DEPTH_WORDS);

    state_t       state_r;
    logic         in_ready_r;
    logic         imem_we_r;
    logic [31:0]  imem_addr_r;
    logic [31:0]  imem_wdata_r;
    logic         core_rst_n_r;
    logic         done_r;
    logic         err_r;
    logic [15:0]  wl_r;
    logic [15:0]  n_r;
    logic [7:0]   acc_r;
    logic [TW-1:0] tmo_r;

    logic         fire_s;
    logic         shift_s;
    logic         clr_s;
    logic         tmo_run_s;
    logic         tmo_hit_s;
    logic [31:0]  word_next_s;
    logic [1:0]   byte_idx_s;
    logic         word_ready_s;

    assign fire_s  = bus.in_valid & in_ready_r;
    assign shift_s = fire_s & ((state_r == HDR) | (state_r == LOAD));
    assign clr_s   = start & ((state_r == DONE) | (state_r == ERR));

    // The idle-gap counter only runs once a frame has actually begun.
    assign tmo_run_s = ((state_r == HDR) & (byte_idx_s != 2'd0)) |
                       (state_r == LOAD) | (state_r == CSUM);
    assign tmo_hit_s = (TIMEOUT != 32'd0) & tmo_run_s & ~fire_s & (tmo_r == TMO_LAST);

    boot_word_asm u_asm (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr_s),
        .shift      (shift_s),
        .din        (bus.in_data),
        .word_next  (word_next_s),
        .byte_idx   (byte_idx_s),
        .word_ready (word_ready_s)
    );

    assign bus.in_ready  = in_ready_r;
    assign imem_we       = imem_we_r;
    assign imem_addr     = imem_addr_r;
    assign imem_wdata    = imem_wdata_r;
    assign core_rst_n    = core_rst_n_r;
    assign done          = done_r;
    assign err           = err_r;
    assign words_loaded  = wl_r;

    // Frame state machine with its counters, checksum and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= HDR;
            in_ready_r   <= 1'b0;
            imem_we_r    <= 1'b0;
            imem_addr_r  <= BASE_ADDR;
            imem_wdata_r <= 32'd0;
            core_rst_n_r <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            wl_r         <= 16'd0;
            n_r          <= 16'd0;
            acc_r        <= 8'd0;
            tmo_r        <= '0;
        end else begin
            imem_we_r <= 1'b0;
            if (fire_s) begin
                tmo_r <= '0;
            end else if (tmo_run_s) begin
                tmo_r <= tmo_r + TW'(1);
            end else begin
                tmo_r <= tmo_r;
            end

            case (state_r)
                HDR: begin
                    if (shift_s && word_ready_s) begin
                        // Length is range-checked at full width before truncation.
                        if ((word_next_s == 32'd0) || (word_next_s > DEPTH_32)) begin
                            state_r    <= ERR;
                            in_ready_r <= 1'b0;
                            err_r      <= 1'b1;
                        end else begin
                            state_r    <= LOAD;
                            in_ready_r <= 1'b1;
                            n_r        <= word_next_s[15:0];
                        end
                    end else if (tmo_hit_s) begin
                        state_r    <= ERR;
                        in_ready_r <= 1'b0;
                        err_r      <= 1'b1;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                LOAD: begin
                    if (shift_s) begin
                        acc_r <= acc_r ^ bus.in_data;
                    end else begin
                        acc_r <= acc_r;
                    end
                    if (shift_s && word_ready_s) begin
                        state_r      <= WRITE;
                        in_ready_r   <= 1'b0;
                        imem_we_r    <= 1'b1;
                        imem_wdata_r <= word_next_s;
                        imem_addr_r  <= BASE_ADDR + {14'd0, wl_r, 2'b00};
                    end else if (tmo_hit_s) begin
                        state_r    <= ERR;
                        in_ready_r <= 1'b0;
                        err_r      <= 1'b1;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                WRITE: begin
                    wl_r       <= wl_r + 16'd1;
                    in_ready_r <= 1'b1;
                    if ((wl_r + 16'd1) == n_r) begin
                        state_r <= CSUM;
                    end else begin
                        state_r <= LOAD;
                    end
                end
                CSUM: begin
                    if (fire_s) begin
                        in_ready_r <= 1'b0;
                        if (bus.in_data == acc_r) begin
                            state_r      <= DONE;
                            done_r       <= 1'b1;
                            core_rst_n_r <= 1'b1;
                        end else begin
                            state_r <= ERR;
                            err_r   <= 1'b1;
                        end
                    end else if (tmo_hit_s) begin
                        state_r    <= ERR;
                        in_ready_r <= 1'b0;
                        err_r      <= 1'b1;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                DONE, ERR: begin
                    // Previously written words are deliberately left in memory.
                    if (start) begin
                        state_r      <= HDR;
                        in_ready_r   <= 1'b1;
                        done_r       <= 1'b0;
                        err_r        <= 1'b0;
                        core_rst_n_r <= 1'b0;
                        wl_r         <= 16'd0;
                        acc_r        <= 8'd0;
                        tmo_r        <= '0;
                    end else begin
                        in_ready_r <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= HDR;
                    in_ready_r   <= 1'b1;
                    done_r       <= 1'b0;
                    err_r        <= 1'b0;
                    core_rst_n_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: good/bad frames, length limits, timeout and mid-frame reset.
module tb_imem_boot_loader;

    localparam int unsigned DW  = 8;
    localparam logic [31:0] BA  = 32'h0000_0000;
    localparam int unsigned TMO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst_n;
    logic        done;
    logic        err;
    logic [15:0] words_loaded;

    int          compared = 0;
    int          mismatched = 0;
    int          we_cnt = 0;
    int          we_snap;
    logic [7:0]  tb_xor;

    imem_boot_loader_if bus ();

    imem_boot_loader #(.DEPTH_WORDS(DW), .BASE_ADDR(BA), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .start        (start),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_rst_n   (core_rst_n),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Count write strobes away from the active edge.
    always @(negedge clk) begin
        if (imem_we) we_cnt <= we_cnt + 1;
    end

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // gap < 0 selects a random idle gap well below the timeout.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int g;
        g = (gap < 0) ? int'($urandom_range(0, 12)) : gap;
        repeat (g) tick();
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int n = 0; n < 40 && !bus.in_ready; n++) tick();
        chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [31:0] n, input int gap);
        tb_xor = 8'd0;
        for (int k = 0; k < 4; k++) send_byte(n[8*k +: 8], gap);
    endtask

    task automatic send_word(input logic [31:0] w, input int idx, input int gap);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8], gap);
            tb_xor = tb_xor ^ w[8*k +: 8];
        end
        chk($sformatf("we_w%0d", idx), 32'(imem_we), 32'd1);
        chk($sformatf("addr_w%0d", idx), imem_addr, BA + 32'(idx) * 32'd4);
        chk($sformatf("wdata_w%0d", idx), imem_wdata, w);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;

        // Reset values
        repeat (3) tick();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", imem_addr, BA);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_core", 32'(core_rst_n), 32'd0);
        chk("rst_wl", 32'(words_loaded), 32'd0);
        rst = 1'b1;
        tick();
        chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rel_core", 32'(core_rst_n), 32'd0);
        chk("rel_done", 32'(done), 32'd0);
        chk("rel_err", 32'(err), 32'd0);
        chk("rel_we", 32'(imem_we), 32'd0);

        // Good two-word image; XOR of payload bytes is 0xC1
        send_hdr(32'd2, 0);
        send_word(32'h0050_0093, 0, 0);
        tick();
        chk("we_drop", 32'(imem_we), 32'd0);
        chk("wl_after_w0", 32'(words_loaded), 32'd1);
        send_word(32'h0010_0113, 1, 0);
        chk("csum_model", 32'(tb_xor), 32'h0000_00C1);
        send_byte(tb_xor, 0);
        chk("a_done", 32'(done), 32'd1);
        chk("a_core", 32'(core_rst_n), 32'd1);
        chk("a_wl", 32'(words_loaded), 32'd2);
        chk("a_err", 32'(err), 32'd0);
        chk("a_in_ready", 32'(bus.in_ready), 32'd0);

        pulse_start();
        chk("restart_done", 32'(done), 32'd0);
        chk("restart_core", 32'(core_rst_n), 32'd0);
        chk("restart_wl", 32'(words_loaded), 32'd0);
        chk("restart_in_ready", 32'(bus.in_ready), 32'd1);

        // Same image with a wrong checksum byte
        send_hdr(32'd2, 0);
        send_word(32'h0050_0093, 0, 0);
        send_word(32'h0010_0113, 1, 0);
        send_byte(8'h83, 0);
        chk("b_err", 32'(err), 32'd1);
        chk("b_core", 32'(core_rst_n), 32'd0);
        chk("b_done", 32'(done), 32'd0);
        pulse_start();
        chk("b_err_clr", 32'(err), 32'd0);
        chk("b_in_ready", 32'(bus.in_ready), 32'd1);
        send_hdr(32'd2, 0);
        send_word(32'h0050_0093, 0, 0);
        send_word(32'h0010_0113, 1, 0);
        send_byte(8'hC1, 0);
        chk("b_reload_done", 32'(done), 32'd1);

        // N = 0 is rejected without any write
        pulse_start();
        we_snap = we_cnt;
        send_hdr(32'd0, 0);
        chk("n0_err", 32'(err), 32'd1);
        tick();
        chk("n0_no_we", 32'(we_cnt), 32'(we_snap));

        // N = DEPTH_WORDS + 1 is rejected
        pulse_start();
        send_hdr(32'(DW + 1), 0);
        chk("nmax1_err", 32'(err), 32'd1);
        tick();
        chk("nmax1_no_we", 32'(we_cnt), 32'(we_snap));

        // N = DEPTH_WORDS loads fully
        pulse_start();
        send_hdr(32'(DW), 0);
        for (int i = 0; i < int'(DW); i++) send_word(32'h1000_0000 + 32'(i) * 32'h0101_0101, i, 0);
        send_byte(tb_xor, 0);
        chk("nmax_done", 32'(done), 32'd1);
        chk("nmax_wl", 32'(words_loaded), 32'(DW));
        chk("nmax_we_cnt", 32'(we_cnt), 32'(we_snap) + 32'(DW));

        // Stall after two payload bytes: err exactly TMO cycles after the last accepted byte
        pulse_start();
        we_snap = we_cnt;
        send_hdr(32'd1, 0);
        send_byte(8'hAA, 0);
        send_byte(8'h55, 0);
        repeat (TMO - 1) tick();
        chk("tmo_before", 32'(err), 32'd0);
        tick();
        chk("tmo_at", 32'(err), 32'd1);
        chk("tmo_no_we", 32'(we_cnt), 32'(we_snap));

        // Random gaps below the timeout are tolerated
        pulse_start();
        send_hdr(32'd2, -1);
        send_word(32'hDEAD_BEEF, 0, -1);
        send_word(32'h1234_5678, 1, -1);
        send_byte(tb_xor, -1);
        chk("gap_done", 32'(done), 32'd1);
        chk("gap_err", 32'(err), 32'd0);

        // Reset mid-frame after six payload bytes
        pulse_start();
        send_hdr(32'd2, 0);
        send_word(32'hCAFE_F00D, 0, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        we_snap = we_cnt;
        rst = 1'b0;
        #1;
        chk("mid_rst_we", 32'(imem_we), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("mid_rst_wl", 32'(words_loaded), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_no_partial", 32'(we_cnt), 32'(we_snap));
        chk("mid_rst_hdr", 32'(bus.in_ready), 32'd1);
        send_hdr(32'd2, 0);
        send_word(32'h0BAD_F00D, 0, 0);
        send_word(32'h5555_AAAA, 1, 0);
        send_byte(tb_xor, 0);
        chk("post_rst_done", 32'(done), 32'd1);
        chk("post_rst_wl", 32'(words_loaded), 32'd2);
        chk("post_rst_we_cnt", 32'(we_cnt), 32'(we_snap) + 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
